// File: rtl/mio_bus_responder_pkg.sv
// -----------------------------------------------------------------------------
// mio_pkg
// Shared definitions for the MIO bus responder: address-map constants,
// the responder FSM state type and the decoded-region type.
// -----------------------------------------------------------------------------
package mio_pkg;

    // Address map (byte addresses; the two LSBs never select a word)
    localparam logic [31:0] RAM_BASE = 32'h0000_0000;
    localparam logic [31:0] LED_ADDR = 32'hE000_0000;
    localparam logic [31:0] SW_ADDR  = 32'hF000_0000;
    localparam logic [31:0] CNT_ADDR = 32'hF000_0004;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } mio_state_e;

    typedef enum logic [2:0] {
        REG_RAM  = 3'd0,
        REG_LED  = 3'd1,
        REG_SW   = 3'd2,
        REG_CNT  = 3'd3,
        REG_NONE = 3'd4
    } mio_region_e;

    // True when two byte addresses name the same 32-bit word
    function automatic logic word_match(input logic [31:0] addr, input logic [31:0] base);
        return (addr[31:2] == base[31:2]);
    endfunction

endpackage

// File: rtl/mio_bus_responder_if.sv
// -----------------------------------------------------------------------------
// mio_bus_responder_if
// CPU-side MIO data bus.
//   master : CPU            (drives CPU_MIO, mem_w, Addr_out, Data_out)
//   slave  : bus responder  (drives Data_in, MIO_ready[, bus_err])
// With MIO_BUS_ERR_EN defined the bus also carries the bus_err pulse.
// -----------------------------------------------------------------------------
interface mio_bus_responder_if;
    logic        CPU_MIO;
    logic        mem_w;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic [31:0] Data_in;
    logic        MIO_ready;
`ifdef MIO_BUS_ERR_EN
    logic        bus_err;

    modport master (output CPU_MIO, mem_w, Addr_out, Data_out,
                    input  Data_in, MIO_ready, bus_err);
    modport slave  (input  CPU_MIO, mem_w, Addr_out, Data_out,
                    output Data_in, MIO_ready, bus_err);
`else
    modport master (output CPU_MIO, mem_w, Addr_out, Data_out,
                    input  Data_in, MIO_ready);
    modport slave  (input  CPU_MIO, mem_w, Addr_out, Data_out,
                    output Data_in, MIO_ready);
`endif
endinterface

// File: rtl/mio_bus_responder_addr_decode.sv
// -----------------------------------------------------------------------------
// mio_addr_decode
// Combinational address decoder for the MIO responder.
//   addr   in  32  CPU byte address
//   mem_w  in  1   access direction (1 = write)
//   region out     selected target (RAM / LED / SW / CNT / NONE)
//   err    out 1   access would be a bus error: unmapped, misaligned, or a
//                  write to the read-only switch word. The top only acts on
//                  it when MIO_BUS_ERR_EN is defined.
// -----------------------------------------------------------------------------
module mio_addr_decode
    import mio_pkg::*;
(
    input  logic [31:0] addr,
    input  logic        mem_w,
    output mio_region_e region,
    output logic        err
);

    // Region select: the whole low 256 MiB aliases onto the RAM
    always_comb begin
        region = REG_NONE;
        if (addr[31:28] == RAM_BASE[31:28]) begin
            region = REG_RAM;
        end else if (word_match(addr, LED_ADDR)) begin
            region = REG_LED;
        end else if (word_match(addr, SW_ADDR)) begin
            region = REG_SW;
        end else if (word_match(addr, CNT_ADDR)) begin
            region = REG_CNT;
        end else begin
            region = REG_NONE;
        end
    end

    assign err = (region == REG_NONE) || (addr[1:0] != 2'b00) ||
                 ((region == REG_SW) && mem_w);

endmodule

// File: rtl/mio_bus_responder.sv
// -----------------------------------------------------------------------------
// mio_bus_responder
// Responder end of the CPU MIO data bus. Decodes each request to data RAM,
// an LED register, synchronised switches or a free-running cycle counter and
// completes it with a one-cycle MIO_ready pulse.
//
// Parameters: RAM_AW (RAM word-address width), RAM_LAT (RAM read latency,
//             1..4), LED_W, SW_W.
// Ports:
//   clk, reset          clock / asynchronous active-low reset
//   bus (slave)         CPU_MIO, mem_w, Addr_out, Data_out -> Data_in, MIO_ready
//   ram_addr/ram_din/ram_we/ram_dout   synchronous RAM port
//   sw_in               raw switches (two-flop synchronised here)
//   led_out             LED register
// Optional: define MIO_BUS_ERR_EN to add bus.bus_err; erroring accesses then
// have no side effect and reads of them return 0xDEAD_BEEF.
// -----------------------------------------------------------------------------
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int RAM_AW  = 10,
    parameter int RAM_LAT = 1,
    parameter int LED_W   = 16,
    parameter int SW_W    = 16
)(
    input  logic                  clk,
    input  logic                  reset,
    mio_bus_responder_if.slave    bus,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic [31:0]           ram_din,
    output logic                  ram_we,
    input  logic [31:0]           ram_dout,
    input  logic [SW_W-1:0]       sw_in,
    output logic [LED_W-1:0]      led_out
);

`ifdef MIO_BUS_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    mio_state_e        state_r;
    logic [1:0]        wait_r;
    logic [31:0]       data_in_r;
    logic              mio_ready_r;
    logic [RAM_AW-1:0] ram_addr_r;
    logic [31:0]       ram_din_r;
    logic              ram_we_r;
    logic [LED_W-1:0]  led_r;
    logic [31:0]       cnt_r;
    logic [SW_W-1:0]   sw_meta_r;
    logic [SW_W-1:0]   sw_sync_r;
`ifdef MIO_BUS_ERR_EN
    logic              bus_err_r;
`endif

    mio_region_e       region_s;
    logic              dec_err_s;
    logic              acc_err_s;
    logic              accept_s;
    logic              ram_acc_s;
    logic              cnt_load_s;
    logic [RAM_AW-1:0] ram_addr_req_s;
    logic [31:0]       rd_data_s;

    mio_addr_decode u_decode (
        .addr   (bus.Addr_out),
        .mem_w  (bus.mem_w),
        .region (region_s),
        .err    (dec_err_s)
    );

    assign acc_err_s      = ERR_EN && dec_err_s;
    assign accept_s       = (state_r == ST_IDLE) && bus.CPU_MIO;
    assign ram_acc_s      = (region_s == REG_RAM) && !acc_err_s;
    assign cnt_load_s     = accept_s && bus.mem_w && (region_s == REG_CNT) && !acc_err_s;
    assign ram_addr_req_s = bus.Addr_out[RAM_AW+1:2];

    // Peripheral read mux, sampled in the accept cycle
    always_comb begin
        rd_data_s = 32'h0000_0000;
        if (acc_err_s) begin
            rd_data_s = ERR_DATA;
        end else begin
            case (region_s)
                REG_LED: rd_data_s = 32'(led_r);
                REG_SW:  rd_data_s = 32'(sw_sync_r);
                REG_CNT: rd_data_s = cnt_r;
                default: rd_data_s = 32'h0000_0000;
            endcase
        end
    end

    // RAM address: the accept-cycle address goes straight to the RAM so that
    // ram_dout lands RAM_LAT cycles later and the read completes at T+1+RAM_LAT;
    // afterwards the latched copy holds it for the write/wait cycles.
    always_comb begin
        if (reset && accept_s && ram_acc_s) begin
            ram_addr = ram_addr_req_s;
        end else begin
            ram_addr = ram_addr_r;
        end
    end

    // Responder FSM with all bus/RAM/LED outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            wait_r      <= 2'd0;
            data_in_r   <= 32'h0000_0000;
            mio_ready_r <= 1'b0;
            ram_addr_r  <= '0;
            ram_din_r   <= 32'h0000_0000;
            ram_we_r    <= 1'b0;
            led_r       <= '0;
`ifdef MIO_BUS_ERR_EN
            bus_err_r   <= 1'b0;
`endif
        end else begin
            mio_ready_r <= 1'b0;
            ram_we_r    <= 1'b0;
`ifdef MIO_BUS_ERR_EN
            bus_err_r   <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (bus.CPU_MIO) begin
                        if (ram_acc_s) begin
                            ram_addr_r <= ram_addr_req_s;
                            if (bus.mem_w) begin
                                ram_din_r   <= bus.Data_out;
                                ram_we_r    <= 1'b1;
                                mio_ready_r <= 1'b1;
                                state_r     <= ST_RESP;
                            end else begin
                                // Counts down to the cycle ram_dout is valid
                                wait_r  <= 2'(RAM_LAT - 1);
                                state_r <= ST_RD_WAIT;
                            end
                        end else begin
                            if (!bus.mem_w) begin
                                data_in_r <= rd_data_s;
                            end else if (!acc_err_s && (region_s == REG_LED)) begin
                                led_r <= bus.Data_out[LED_W-1:0];
                            end else begin
                                led_r <= led_r;
                            end
`ifdef MIO_BUS_ERR_EN
                            bus_err_r   <= acc_err_s;
`endif
                            mio_ready_r <= 1'b1;
                            state_r     <= ST_RESP;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD_WAIT: begin
                    if (wait_r == 2'd0) begin
                        data_in_r   <= ram_dout;
                        mio_ready_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        wait_r <= wait_r - 2'd1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Free-running counter; a CPU write wins over the increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= 32'h0000_0000;
        end else if (cnt_load_s) begin
            cnt_r <= bus.Data_out;
        end else begin
            cnt_r <= cnt_r + 32'd1;
        end
    end

    // Two-flop synchroniser for the asynchronous switch inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_r <= '0;
            sw_sync_r <= '0;
        end else begin
            sw_meta_r <= sw_in;
            sw_sync_r <= sw_meta_r;
        end
    end

    assign bus.Data_in   = data_in_r;
    assign bus.MIO_ready = mio_ready_r;
`ifdef MIO_BUS_ERR_EN
    assign bus.bus_err   = bus_err_r;
`endif
    assign ram_din = ram_din_r;
    assign ram_we  = ram_we_r;
    assign led_out = led_r;

endmodule
